fifo_ctrl_lvl: RTL and testbench
================================

// Module: fifo_ctrl_lvl
// PURPOSE
// - Next-generation FIFO controller: read/write pointers, registered occupancy level and registered status flags.
// - Adds almost-full/almost-empty thresholds, qualified enables and overflow/underflow error reporting.
// - Defines legal simultaneous read/write at the empty and full boundaries.
// - Drives an external dual-port register file of 2**ADDR_WIDTH words; sits between producer and consumer datapaths.
// PARAMETERS
// - ADDR_WIDTH     3           address bits; DEPTH = 2**ADDR_WIDTH
// - AFULL_THRESH   DEPTH-1     almost_full asserts when level >= AFULL_THRESH
// - AEMPTY_THRESH  1           almost_empty asserts when level <= AEMPTY_THRESH
// PORTS
// - clk           in   1             single clock, rising edge
// - reset_n       in   1             asynchronous, active-low reset
// - wr            in   1             write request
// - rd            in   1             read request
// - we            out  1             qualified write enable to register file (comb)
// - w_addr        out  ADDR_WIDTH    write address
// - r_addr        out  ADDR_WIDTH    current read address
// - r_addr_next   out  ADDR_WIDTH    read address after this cycle (for synchronous-read RAM)
// - level         out  ADDR_WIDTH+1  occupancy, 0..DEPTH
// - empty/full    out  1             registered status
// - almost_empty  out  1             registered, level <= AEMPTY_THRESH
// - almost_full   out  1             registered, level >= AFULL_THRESH
// - overflow      out  1             write rejected (see CONFIGURATION)
// - underflow     out  1             read rejected (see CONFIGURATION)
// - clr_err       in   1             clears sticky errors; port exists only with the macro
// BEHAVIOUR
// - Reset (async, reset_n=0): pointers=0, level=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
// - Pointers are ADDR_WIDTH+1 bits; addresses are the low ADDR_WIDTH bits; wrap from DEPTH-1 to 0.
// - Level arithmetic is modulo 2**(ADDR_WIDTH+1).
// - wr_ok = wr & (~full | rd).
// - rd_ok = rd & ~empty. Read while empty is never accepted; a bypass path does not exist.
// - we = wr_ok.
// - On each edge: w_ptr += wr_ok; r_ptr += rd_ok; level += wr_ok - rd_ok.
// - Flags update on the same edge from level_next; one-cycle latency from request to flag.
// - Simultaneous rd&wr:
//   - empty: write only; level -> 1; underflow event.
//   - full: both accepted; level stays DEPTH; full stays 1.
//   - otherwise: both accepted; level unchanged.
// - Events: overflow_ev = wr & full & ~rd; underflow_ev = rd & empty.
// - r_addr_next = low bits of (r_ptr + rd_ok), combinational.
// - Reset mid-operation: all state returns to reset values immediately; in-flight requests are discarded.
// - Invariant: full == (level == DEPTH); empty == (level == 0). Never both set.
// CONFIGURATION
// - Macro FIFO_CTRL_STICKY_ERR_EN:
//   - defined: overflow/underflow set on event and hold until a clr_err pulse or reset.
//   - defined: clr_err and a same-cycle event gives event priority (flag stays 1).
// - Without the macro: overflow/underflow are registered single-cycle pulses, one cycle after the event; clr_err is absent.
// STRUCTURE
// - Package fifo_pkg:
//   - DEPTH derivation function.
//   - Default threshold constants.
//   - Localparam PTR_W = ADDR_WIDTH+1.
// - One sub-module fifo_lvl_flags: registered level -> empty/full/almost flags, reused by later async FIFO variants.
// - Pointer/level update logic stays in the top module.
// TESTING
// - Reset: assert reset_n=0 mid-traffic -> all outputs at reset values without a clock edge.
// - Fill, ADDR_WIDTH=3: 8 writes -> level 1..8; almost_full at level 7; full after 8th write; w_addr wraps 7->0.
// - 9th write while full -> we=0, level stays 8, overflow=1; pulse without macro, sticky with macro until clr_err.
// - Full with rd=wr=1 for 4 cycles -> level 8 constant; r_addr and w_addr both advance by 4.
// - Empty with rd=wr=1 -> we=1, level=1, empty=0, underflow raised; then rd alone -> level 0, empty=1, almost_empty=1.
// - Drain: rd alone while empty -> r_addr_next == r_addr, underflow=1, level stays 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller family: depth and pointer-width
// helpers, default thresholds and the packed status-flag bundle.
// The FIFO_CTRL_STICKY_ERR_EN macro (used by fifo_ctrl_lvl) needs nothing here.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH    = 3;
  localparam int PTR_W             = DEF_ADDR_WIDTH + 1;
  localparam int DEF_AEMPTY_THRESH = 1;

  // Number of words addressed by an aw-bit address.
  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  // Pointers carry one extra bit so that a full FIFO and an empty FIFO differ.
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

  // Almost-full defaults to one word short of full.
  function automatic int def_afull_thresh(input int aw);
    return fifo_depth(aw) - 1;
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_lvl_flags.sv
// Registered status flags derived from the next occupancy level.
// Kept separate so other FIFO variants (e.g. async) can reuse the same
// level-to-flag mapping. Reset state corresponds to an empty FIFO.
module fifo_lvl_flags
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int AFULL_THRESH  = def_afull_thresh(ADDR_WIDTH),
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH:0]   level_next,
  output fifo_flags_t           flags
);

  localparam int                  PTR_BITS = ptr_width(ADDR_WIDTH);
  localparam logic [PTR_BITS-1:0] DEPTH_L  = PTR_BITS'(fifo_depth(ADDR_WIDTH));
  localparam logic [PTR_BITS-1:0] AF_L     = PTR_BITS'(AFULL_THRESH);
  localparam logic [PTR_BITS-1:0] AE_L     = PTR_BITS'(AEMPTY_THRESH);

  fifo_flags_t flags_d;
  fifo_flags_t flags_q;

  // Map the upcoming level onto each status flag.
  always_comb begin
    flags_d              = '0;
    flags_d.empty        = (level_next == '0);
    flags_d.full         = (level_next == DEPTH_L);
    flags_d.almost_empty = (level_next <= AE_L);
    flags_d.almost_full  = (level_next >= AF_L);
  end

  // Flags register on the same edge as the level itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q.empty        <= 1'b1;
      flags_q.full         <= 1'b0;
      flags_q.almost_empty <= 1'b1;
      flags_q.almost_full  <= 1'b0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;

endmodule

// File: rtl/fifo_ctrl_lvl.sv
// FIFO controller for an external dual-port register file: read/write
// pointers, registered occupancy level, status flags and error reporting.
// Optional macro FIFO_CTRL_STICKY_ERR_EN: overflow/underflow become sticky
// and a clr_err input clears them; otherwise they are one-cycle pulses.
module fifo_ctrl_lvl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int AFULL_THRESH  = def_afull_thresh(ADDR_WIDTH),
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
`ifdef FIFO_CTRL_STICKY_ERR_EN
  input  logic                  clr_err,
`endif
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [ADDR_WIDTH-1:0] r_addr_next,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_BITS = ptr_width(ADDR_WIDTH);

  logic [PTR_BITS-1:0] w_ptr_q, w_ptr_d;
  logic [PTR_BITS-1:0] r_ptr_q, r_ptr_d;
  logic [PTR_BITS-1:0] level_q, level_d;
  logic                wr_ok, rd_ok;
  logic                overflow_ev, underflow_ev;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  fifo_flags_t         flags;

  // Qualify requests against the registered flags. A write while full is
  // allowed only when a read frees a slot in the same cycle; a read while
  // empty is always refused because there is no bypass path.
  always_comb begin
    wr_ok        = wr & (~flags.full | rd);
    rd_ok        = rd & ~flags.empty;
    overflow_ev  = wr & flags.full & ~rd;
    underflow_ev = rd & flags.empty;
  end

  // Advance pointers and level by whatever was accepted this cycle; level
  // arithmetic simply wraps at the pointer width.
  always_comb begin
    w_ptr_d = w_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_ok};
    r_ptr_d = r_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_ok};
    level_d = level_q + {{ADDR_WIDTH{1'b0}}, wr_ok} - {{ADDR_WIDTH{1'b0}}, rd_ok};
  end

  // Pointer and level state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      level_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      level_q <= level_d;
    end
  end

  // Next error state: either held until cleared, or a plain registered pulse.
  always_comb begin
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
`ifdef FIFO_CTRL_STICKY_ERR_EN
    overflow_d  = overflow_ev  | (overflow_q  & ~clr_err);
    underflow_d = underflow_ev | (underflow_q & ~clr_err);
`else
    overflow_d  = overflow_ev;
    underflow_d = underflow_ev;
`endif
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_lvl_flags #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .AFULL_THRESH  (AFULL_THRESH),
    .AEMPTY_THRESH (AEMPTY_THRESH)
  ) u_flags (
    .clk        (clk),
    .reset_n    (reset_n),
    .level_next (level_d),
    .flags      (flags)
  );

  assign we           = wr_ok;
  assign w_addr       = w_ptr_q[ADDR_WIDTH-1:0];
  assign r_addr       = r_ptr_q[ADDR_WIDTH-1:0];
  assign r_addr_next  = r_ptr_d[ADDR_WIDTH-1:0];
  assign level        = level_q;
  assign empty        = flags.empty;
  assign full         = flags.full;
  assign almost_empty = flags.almost_empty;
  assign almost_full  = flags.almost_full;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl_lvl.sv
// Directed testbench for fifo_ctrl_lvl with ADDR_WIDTH=3 (DEPTH=8).
// Build with FIFO_CTRL_STICKY_ERR_EN defined to exercise sticky errors.
module tb_fifo_ctrl_lvl;

  logic       clk;
  logic       reset_n;
  logic       wr;
  logic       rd;
`ifdef FIFO_CTRL_STICKY_ERR_EN
  logic       clrErr;
`endif
  logic       we;
  logic [2:0] w_addr;
  logic [2:0] r_addr;
  logic [2:0] r_addr_next;
  logic [3:0] level;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic       overflow;
  logic       underflow;

  int vectors;
  int miscompares;

  fifo_ctrl_lvl #(.ADDR_WIDTH(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr           (wr),
    .rd           (rd),
`ifdef FIFO_CTRL_STICKY_ERR_EN
    .clr_err      (clrErr),
`endif
    .we           (we),
    .w_addr       (w_addr),
    .r_addr       (r_addr),
    .r_addr_next  (r_addr_next),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Free-running 10ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic w, input logic r);
    wr = w;
    rd = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every output that has a defined reset value.
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_level"}, 32'(level), 0);
    checkOutput({tag, "_empty"}, 32'(empty), 1);
    checkOutput({tag, "_full"}, 32'(full), 0);
    checkOutput({tag, "_aempty"}, 32'(almost_empty), 1);
    checkOutput({tag, "_afull"}, 32'(almost_full), 0);
    checkOutput({tag, "_ovf"}, 32'(overflow), 0);
    checkOutput({tag, "_unf"}, 32'(underflow), 0);
    checkOutput({tag, "_waddr"}, 32'(w_addr), 0);
    checkOutput({tag, "_raddr"}, 32'(r_addr), 0);
  endtask

  // Linear directed sequence with hand-derived expectations.
  initial begin
    vectors     = 0;
    miscompares = 0;
    wr          = 1'b0;
    rd          = 1'b0;
`ifdef FIFO_CTRL_STICKY_ERR_EN
    clrErr      = 1'b0;
`endif
    reset_n     = 1'b1;
    #2 reset_n  = 1'b0;
    #5;
    checkResetState("rst");
    checkOutput("rst_we", 32'(we), 0);
    checkOutput("rst_raddr_next", 32'(r_addr_next), 0);

    @(posedge clk);
    #1 reset_n = 1'b1;

    // Fill: eight writes, level counts up 1..8.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("fill_we", 32'(we), 1);
      checkOutput("fill_waddr", 32'(w_addr), 32'(i));
      tick();
      checkOutput("fill_level", 32'(level), 32'(i + 1));
      checkOutput("fill_afull", 32'(almost_full), 32'((i + 1) >= 7));
      checkOutput("fill_full", 32'(full), 32'((i + 1) == 8));
      checkOutput("fill_empty", 32'(empty), 0);
      checkOutput("fill_aempty", 32'(almost_empty), 32'((i + 1) <= 1));
    end
    checkOutput("fill_wrap_waddr", 32'(w_addr), 0);

    // Ninth write while full is rejected.
    applyStimulus(1'b1, 1'b0);
    checkOutput("ovf_we", 32'(we), 0);
    tick();
    checkOutput("ovf_level", 32'(level), 8);
    checkOutput("ovf_flag", 32'(overflow), 1);
    checkOutput("ovf_waddr", 32'(w_addr), 0);
    applyStimulus(1'b0, 1'b0);
    tick();
`ifdef FIFO_CTRL_STICKY_ERR_EN
    checkOutput("ovf_sticky_hold", 32'(overflow), 1);
    // Clear coinciding with a fresh overflow event: the event wins.
    wr = 1'b1;
    clrErr = 1'b1;
    tick();
    checkOutput("ovf_clr_vs_event", 32'(overflow), 1);
    wr = 1'b0;
    tick();
    checkOutput("ovf_clr", 32'(overflow), 0);
    clrErr = 1'b0;
    tick();
    checkOutput("ovf_after_clr", 32'(overflow), 0);
`else
    checkOutput("ovf_pulse_end", 32'(overflow), 0);
`endif

    // Full with simultaneous read and write for four cycles.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput("fullrw_we", 32'(we), 1);
      tick();
      checkOutput("fullrw_level", 32'(level), 8);
      checkOutput("fullrw_full", 32'(full), 1);
      checkOutput("fullrw_ovf", 32'(overflow), 0);
    end
    checkOutput("fullrw_raddr", 32'(r_addr), 4);
    checkOutput("fullrw_waddr", 32'(w_addr), 4);

    // Drain all eight words; r_addr goes 4 -> 12 mod 8 = 4.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("drain_raddr_next", 32'(r_addr_next), 32'((4 + i + 1) % 8));
      tick();
      checkOutput("drain_level", 32'(level), 32'(7 - i));
      checkOutput("drain_empty", 32'(empty), 32'((7 - i) == 0));
      checkOutput("drain_aempty", 32'(almost_empty), 32'((7 - i) <= 1));
      checkOutput("drain_afull", 32'(almost_full), 32'((7 - i) >= 7));
      checkOutput("drain_unf", 32'(underflow), 0);
    end
    checkOutput("drain_raddr", 32'(r_addr), 4);

    // Empty with simultaneous read and write: only the write is accepted.
    applyStimulus(1'b1, 1'b1);
    checkOutput("emptyrw_we", 32'(we), 1);
    checkOutput("emptyrw_raddr_next", 32'(r_addr_next), 4);
    tick();
    checkOutput("emptyrw_level", 32'(level), 1);
    checkOutput("emptyrw_empty", 32'(empty), 0);
    checkOutput("emptyrw_aempty", 32'(almost_empty), 1);
    checkOutput("emptyrw_unf", 32'(underflow), 1);
    checkOutput("emptyrw_waddr", 32'(w_addr), 5);
    checkOutput("emptyrw_raddr", 32'(r_addr), 4);

    // Read the single word back out.
    applyStimulus(1'b0, 1'b1);
    checkOutput("rd1_raddr_next", 32'(r_addr_next), 5);
    tick();
    checkOutput("rd1_level", 32'(level), 0);
    checkOutput("rd1_empty", 32'(empty), 1);
    checkOutput("rd1_aempty", 32'(almost_empty), 1);
`ifdef FIFO_CTRL_STICKY_ERR_EN
    checkOutput("rd1_unf_sticky", 32'(underflow), 1);
    rd = 1'b0;
    clrErr = 1'b1;
    tick();
    clrErr = 1'b0;
    checkOutput("rd1_unf_clr", 32'(underflow), 0);
`else
    checkOutput("rd1_unf_pulse_end", 32'(underflow), 0);
`endif

    // Read while empty: refused, address does not move.
    applyStimulus(1'b0, 1'b1);
    checkOutput("unf_raddr_next", 32'(r_addr_next), 5);
    checkOutput("unf_we", 32'(we), 0);
    tick();
    checkOutput("unf_flag", 32'(underflow), 1);
    checkOutput("unf_level", 32'(level), 0);
    checkOutput("unf_raddr", 32'(r_addr), 5);

    // Reset in the middle of traffic, observed without any clock edge.
    applyStimulus(1'b1, 1'b0);
    tick();
    tick();
    checkOutput("pre_rst_level", 32'(level), 2);
    #2 reset_n = 1'b0;
    #1;
    checkResetState("midrst");
    applyStimulus(1'b0, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    checkResetState("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
